ccff_chain_loader: RTL and testbench



---
 rtl/ccff_ctrl_pkg.sv | 22 ++
 rtl/ccff_crc8.sv | 27 ++
 rtl/ccff_chain_loader.sv | 122 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_ctrl_pkg.sv
// Shared types and constants for the configuration flip-flop chain loader.
// The CRC helper is only referenced when CCFF_READBACK_CRC_EN is defined.
package ccff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One step of an MSB-first CRC-8 LFSR fed with a single serial bit.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial-in CRC-8 register over the chain's tail stream.
// Compiled only when CCFF_READBACK_CRC_EN is defined.
`ifdef CCFF_READBACK_CRC_EN
module ccff_crc8
    import ccff_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       din,
    output logic [7:0] crc
);

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC8_INIT;
        end else if (clr) begin
            crc <= CRC8_INIT;
        end else if (en) begin
            crc <= crc8_next(crc, din);
        end
    end

endmodule
`endif

// File: rtl/ccff_chain_loader.sv
// Streams configuration words LSB-first into a tile's ccff chain, issuing exactly
// CHAIN_LEN shift enables per load. Optional tail readback CRC: CCFF_READBACK_CRC_EN.
module ccff_chain_loader
    import ccff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [7:0]        readback_crc
);

    localparam int                WC_W      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CHAIN_LEN);
    localparam logic [WC_W-1:0]   WORD_FULL = WC_W'(WORD_W);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sreg_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic [CNT_W-1:0]  bit_inc;
    logic              word_last;
    logic              prefetch_ok;
    logic              ready_c;
    logic              accept;
    logic              load_start;

    assign bit_inc     = bit_count + CNT_W'(1);
    assign word_last   = (word_cnt_q == WC_W'(1));
    // A new word may only overlap the last bit of the current one if the chain still needs bits.
    assign prefetch_ok = word_last && (bit_inc < LAST_CNT);
    assign accept      = cfg_valid && ready_c;
    assign load_start  = (state_q == IDLE) && start && !abort;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                ready_c = 1'b1;
                if (cfg_valid) state_d = SHIFT;
            end
            SHIFT: begin
                ready_c = prefetch_ok;
                if (bit_inc == LAST_CNT)                       state_d = DONE;
                else if (word_last && !(cfg_valid && prefetch_ok)) state_d = LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            ready_c = 1'b0;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            sreg_q     <= '0;
            word_cnt_q <= '0;
            bit_count  <= '0;
        end else begin
            if (load_start) begin
                bit_count <= '0;
            end else if (state_q == SHIFT) begin
                bit_count <= bit_inc;
            end
            if (accept) begin
                sreg_q     <= cfg_data;
                word_cnt_q <= WORD_FULL;
            end else if (state_q == SHIFT) begin
                sreg_q     <= sreg_q >> 1;
                word_cnt_q <= word_cnt_q - WC_W'(1);
            end
        end
    end

    // Chain-facing outputs depend on flops only, keeping the clock-gate enable glitch-free.
    assign ccff_clk_en = (state_q == SHIFT);
    assign ccff_head   = ccff_clk_en && sreg_q[0];
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE) && !abort;
    assign cfg_ready   = ready_c;

`ifdef CCFF_READBACK_CRC_EN
    ccff_crc8 u_crc8 (
        .clk   (prog_clk),
        .rst_n (prog_reset),
        .en    (ccff_clk_en),
        .clr   (load_start),
        .din   (ccff_tail),
        .crc   (readback_crc)
    );
`else
    logic unused_tail;
    assign unused_tail  = ccff_tail;
    assign readback_crc = 8'h00;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: expected head bits are queued at stimulus
// time and a negedge monitor pops and compares them on every shift enable.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    logic              prog_clk   = 1'b0;
    logic              prog_reset = 1'b0;
    logic              start      = 1'b0;
    logic              abort      = 1'b0;
    logic [WORD_W-1:0] cfg_data   = '0;
    logic              cfg_valid  = 1'b0;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_clk_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_count;
    logic [7:0]        readback_crc;

    logic [CHAIN_LEN-1:0] chain = '0;

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   en_count   = 0;
    int   done_count = 0;
    int   hs_count   = 0;
    int   first_en   = -1;
    int   last_en    = 0;
    logic exp_q[$];

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .abort        (abort),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .ccff_clk_en  (ccff_clk_en),
        .busy         (busy),
        .done         (done),
        .bit_count    (bit_count),
        .readback_crc (readback_crc)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural chain: head enters at the top, tail leaves from bit 0.
    assign ccff_tail = chain[0];
    always @(posedge prog_clk) begin
        if (ccff_clk_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge prog_clk) begin
        cyc++;
        if (prog_reset) begin
            if (cfg_valid && cfg_ready) hs_count++;
            if (done) done_count++;
            if (ccff_clk_en) begin
                en_count++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                check("head_expected_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("head_bit", 32'(ccff_head), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [7:0] crc_model(input logic [CHAIN_LEN-1:0] bits);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            fb = c[7] ^ bits[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic clear_counts();
        en_count   = 0;
        done_count = 0;
        hs_count   = 0;
        first_en   = -1;
        last_en    = 0;
    endtask

    task automatic push_bits(input logic [23:0] pat, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pat[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input int stall);
        int n;
        if (stall > 0) begin
            cfg_valid = 1'b0;
            n = 0;
            do begin
                @(negedge prog_clk);
                n++;
            end while (ccff_clk_en && n < 50);
            repeat (stall) begin
                @(negedge prog_clk);
                check("stall_no_shift", 32'(ccff_clk_en), 32'd0);
            end
            @(posedge prog_clk);
            #1;
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        check("cfg_ready_seen", 32'(cfg_ready), 32'd1);
        @(posedge prog_clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] w0, w1, w2, input int stall, input bit poke_start);
        logic [23:0]          pat;
        logic [CHAIN_LEN-1:0] prev;
        logic [7:0]           exp_crc;
        int                   n;
        pat  = {w2, w1, w0};
        prev = chain;
`ifdef CCFF_READBACK_CRC_EN
        exp_crc = crc_model(prev);
`else
        exp_crc = 8'h00;
`endif
        clear_counts();
        push_bits(pat, CHAIN_LEN);
        pulse_start();
        check("start_bit_count_clear", 32'(bit_count), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        send_word(w0, 0);
        if (poke_start) pulse_start();
        send_word(w1, stall);
        send_word(w2, stall);
        n = 0;
        while (!done && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_bit_count", 32'(bit_count), CHAIN_LEN);
        check("readback_crc", 32'(readback_crc), 32'(exp_crc));
        check("chain_contents", 32'(chain), 32'(pat[CHAIN_LEN-1:0]));
        @(negedge prog_clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("bit_count_hold", 32'(bit_count), CHAIN_LEN);
        check("enable_total", 32'(en_count), CHAIN_LEN);
        check("done_pulses", 32'(done_count), 32'd1);
        check("handshakes", 32'(hs_count), 32'd3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (stall == 0) check("enables_contiguous", 32'(last_en - first_en + 1), CHAIN_LEN);
        @(posedge prog_clk);
        #1;
    endtask

    initial begin
        int n;
        #1;
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_head", 32'(ccff_head), 32'd0);
        check("rst_clk_en", 32'(ccff_clk_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bit_count", 32'(bit_count), 32'd0);
        check("rst_crc", 32'(readback_crc), 32'd0);
        #20 prog_reset = 1'b1;

        // Back-to-back load into an all-zero chain: readback CRC must be 0x00.
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);
        // Stalled source, same words; readback streams the previous pattern.
        run_load(8'hA5, 8'h3C, 8'h0F, 5, 1'b0);
        // Start pulsed during SHIFT must be ignored; upper bits of last word discarded.
        run_load(8'h96, 8'h01, 8'hE7, 0, 1'b1);

        // start together with abort in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge prog_clk);
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_ready", 32'(cfg_ready), 32'd0);
        check("start_abort_clk_en", 32'(ccff_clk_en), 32'd0);
        @(posedge prog_clk);
        #1;

        // Abort after 11 shifted bits; the 12th enable cycle is the abort cycle.
        clear_counts();
        push_bits({8'h0F, 8'h3C, 8'hA5}, 12);
        pulse_start();
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        n = 0;
        while (bit_count != CNT_W'(11) && n < 50) begin
            @(negedge prog_clk);
            n++;
        end
        check("abort_at_11", 32'(bit_count), 32'd11);
        abort = 1'b1;
        @(posedge prog_clk);
        #1 abort = 1'b0;
        @(negedge prog_clk);
        check("abort_clk_en", 32'(ccff_clk_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge prog_clk);
        check("abort_no_done", 32'(done_count), 32'd0);
        check("abort_enables", 32'(en_count), 32'd12);
        exp_q.delete();
        @(posedge prog_clk);
        #1;
        run_load(8'h5A, 8'hC3, 8'hF0, 0, 1'b0);

        // Asynchronous reset mid-SHIFT, applied away from the clock edge.
        clear_counts();
        push_bits({8'h0F, 8'h3C, 8'hA5}, CHAIN_LEN);
        pulse_start();
        send_word(8'hA5, 0);
        repeat (3) @(posedge prog_clk);
        #3 prog_reset = 1'b0;
        #1;
        check("arst_clk_en", 32'(ccff_clk_en), 32'd0);
        check("arst_head", 32'(ccff_head), 32'd0);
        check("arst_ready", 32'(cfg_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_bit_count", 32'(bit_count), 32'd0);
        check("arst_crc", 32'(readback_crc), 32'd0);
        exp_q.delete();
        #7 prog_reset = 1'b1;
        @(posedge prog_clk);
        #1;
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
